// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector.
//   clog2()       : ceiling log2, used to size length and fill fields
//   MODE_OVL/NOVL : overlap mode encodings for the Mode_Overlap bit
//   fill_state_t  : states of the fill-counter FSM
package seq_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam logic MODE_OVL  = 1'b1;
  localparam logic MODE_NOVL = 1'b0;

  // EMPTY   : no valid history bits
  // FILLING : some history, not yet enough for a full pattern
  // ARMED   : the next valid bit can complete a pattern
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } fill_state_t;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial-stream and programming bus of the pattern detector.
//   master : drives X, X_Valid, Load, Pattern_In, Len_In, Mode_Overlap;
//            receives Out and Match_Count
//   slave  : the detector side (mirror directions)
interface seq_detect_param_if
  import seq_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  localparam int LEN_W = clog2(PAT_W + 1);

  logic             X;
  logic             X_Valid;
  logic             Load;
  logic [PAT_W-1:0] Pattern_In;
  logic [LEN_W-1:0] Len_In;
  logic             Mode_Overlap;
  logic             Out;
  logic [CNT_W-1:0] Match_Count;

  modport master (
    output X, X_Valid, Load, Pattern_In, Len_In, Mode_Overlap,
    input  Out, Match_Count
  );

  modport slave (
    input  X, X_Valid, Load, Pattern_In, Len_In, Mode_Overlap,
    output Out, Match_Count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   Clock : clock
//   Clr   : synchronous active-high reset (to zero)
//   Clear : synchronous clear (to zero)
//   Inc   : increment request; ignored once the count is all ones
//   Count : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Clr,
  input  logic         Clear,
  input  logic         Inc,
  output logic [W-1:0] Count
);
  logic [W-1:0] count_reg;

  always_ff @(posedge Clock) begin
    if (Clr || Clear) begin
      count_reg <= '0;
    end else if (Inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign Count = count_reg;
endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-pattern detector (Mealy).
//   Clock : clock
//   Clr   : synchronous active-high reset; overrides Load and X_Valid
//   bus   : slave side of seq_detect_param_if
//           X/X_Valid      serial bit and its qualifier
//           Load           captures Pattern_In/Len_In/Mode_Overlap
//           Out            combinational match flag on the last pattern bit
//           Match_Count    saturating match count since Clr/Load
// With default parameters this is the classic overlapping "101" detector.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(3'b101),
  parameter int               LEN_DEFAULT = 3,
  parameter bit               OVL_DEFAULT = MODE_OVL,
  parameter int               CNT_W       = 8
) (
  input logic              Clock,
  input logic              Clr,
  seq_detect_param_if.slave bus
);
  localparam int               LEN_W   = clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(LEN_DEFAULT);
  // A single-bit pattern is armed even with empty history.
  localparam fill_state_t      STATE_RST = (LEN_DEFAULT <= 1) ? ARMED : EMPTY;

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;
  // The oldest history bit would only ever be shifted out, never compared,
  // so only PAT_W-1 bits are kept; together with X they form the candidate.
  logic [PAT_W-2:0] hist_reg;
  logic [LEN_W-1:0] fill_reg, fill_next;
  fill_state_t      state_reg, state_next;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] len_load;
  logic [LEN_W-1:0] fill_inc;
  logic             len_hi;
  logic             match;
  logic [CNT_W-1:0] match_count;

  assign cand = {hist_reg, bus.X};

  // Only the low len_reg bits take part in the comparison.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  // Out-of-range lengths only exist when the field can encode more than PAT_W.
  generate
    if (PAT_W < (1 << LEN_W) - 1) begin : g_clamp
      assign len_hi = (bus.Len_In > LEN_MAX);
    end else begin : g_noclamp
      assign len_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    len_load = bus.Len_In;
    if (bus.Len_In == '0) len_load = LEN_W'(1);
    else if (len_hi)      len_load = LEN_MAX;
  end

  assign fill_inc = (fill_reg == LEN_MAX) ? fill_reg : fill_reg + LEN_W'(1);

  // ARMED means fill+1 >= len, i.e. the incoming bit can complete a pattern.
  function automatic fill_state_t classify(input logic [LEN_W-1:0] fill,
                                           input logic [LEN_W-1:0] len);
    if (({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len}) return ARMED;
    else if (fill == '0)                                return EMPTY;
    else                                                return FILLING;
  endfunction

  // Pattern configuration and history.
  always_ff @(posedge Clock) begin
    if (Clr) begin
      pat_reg  <= PAT_DEFAULT;
      len_reg  <= LEN_RST;
      ovl_reg  <= OVL_DEFAULT;
      hist_reg <= '0;
    end else if (bus.Load) begin
      pat_reg  <= bus.Pattern_In;
      len_reg  <= len_load;
      ovl_reg  <= bus.Mode_Overlap;
      hist_reg <= '0;
    end else if (bus.X_Valid) begin
      hist_reg <= cand[PAT_W-2:0];
    end
  end

  // Fill FSM: state register.
  always_ff @(posedge Clock) begin
    if (Clr) begin
      fill_reg  <= '0;
      state_reg <= STATE_RST;
    end else begin
      fill_reg  <= fill_next;
      state_reg <= state_next;
    end
  end

  // Fill FSM: next state.
  always_comb begin
    fill_next  = fill_reg;
    state_next = state_reg;
    if (bus.Load) begin
      fill_next  = '0;
      state_next = classify('0, len_load);
    end else if (bus.X_Valid) begin
      // A non-overlapping match discards the history so the next match
      // needs a full set of fresh bits.
      if (match && (ovl_reg == MODE_NOVL)) fill_next = '0;
      else                                 fill_next = fill_inc;
      state_next = classify(fill_next, len_reg);
    end
  end

  // Fill FSM: output (Mealy match).
  always_comb begin
    match = 1'b0;
    if (!Clr && !bus.Load && bus.X_Valid && (state_reg == ARMED)) begin
      match = (((cand ^ pat_reg) & len_mask) == '0);
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .Clock (Clock),
    .Clr   (Clr),
    .Clear (bus.Load),
    .Inc   (match),
    .Count (match_count)
  );

  assign bus.Out         = match;
  assign bus.Match_Count = match_count;
endmodule
